// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use stalls, branch flushes,
// memory-wait freezes and debug halt/drain for the 5-stage core.
module hazard_stall_controller #(
    parameter int LOAD_USE_STALL_CYCLES = 1,
    parameter int DRAIN_CYCLES          = 3,
    parameter int CNT_WIDTH             = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [4:0]           id_rs1_address,
    input  logic [4:0]           id_rs2_address,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd_address,
    input  logic                 ex_reg_wren,
    input  logic                 ex_is_load,
    input  logic                 ex_branch_taken,
    input  logic                 mem_busy,
    input  logic                 halt_req,
    output logic                 pc_wren,
    output logic                 if_id_wren,
    output logic                 if_id_flush,
    output logic                 id_ex_wren,
    output logic                 id_ex_bubble,
    output logic                 ex_mem_wren,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_LOAD_STALL = 2'd1;
    localparam logic [1:0] S_DRAIN      = 2'd2;
    localparam logic [1:0] S_HALTED     = 2'd3;

    // The first stall cycle is spent in RUN, so LOAD_STALL covers
    // the remaining LOAD_USE_STALL_CYCLES-1 cycles (cnt counts to 0).
    localparam logic [3:0] LS_INIT =
        (LOAD_USE_STALL_CYCLES > 1) ? 4'(LOAD_USE_STALL_CYCLES - 2) : 4'd0;
    localparam logic [3:0] DR_INIT = 4'(DRAIN_CYCLES - 1);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_flush_count;

    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_stall_inc;
    logic       w_flush_inc;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;

    logic w_pc_wren;
    logic w_if_id_wren;
    logic w_if_id_flush;
    logic w_id_ex_wren;
    logic w_id_ex_bubble;
    logic w_ex_mem_wren;
    logic w_halted;

    // Load-use hazard: EX load writes a nonzero rd that ID reads.
    always_comb begin
        w_rs1_hit  = id_uses_rs1 & (id_rs1_address == ex_rd_address);
        w_rs2_hit  = id_uses_rs2 & (id_rs2_address == ex_rd_address);
        w_load_use = ex_is_load & ex_reg_wren
                   & (ex_rd_address != 5'd0)
                   & (w_rs1_hit | w_rs2_hit);
    end

    // Per-cycle control outputs and next state.
    always_comb begin
        w_pc_wren      = 1'b1;
        w_if_id_wren   = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_wren   = 1'b1;
        w_id_ex_bubble = 1'b0;
        w_ex_mem_wren  = 1'b1;
        w_halted       = 1'b0;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;

        if (r_state == S_HALTED) begin
            // Frozen; a pending RAM wait is irrelevant here.
            w_pc_wren     = 1'b0;
            w_if_id_wren  = 1'b0;
            w_id_ex_wren  = 1'b0;
            w_ex_mem_wren = 1'b0;
            w_halted      = 1'b1;
            if (!halt_req) begin
                w_state_nxt = S_RUN;
            end
        end else if (mem_busy) begin
            // Whole pipe freezes; state and cnt hold.
            w_pc_wren     = 1'b0;
            w_if_id_wren  = 1'b0;
            w_id_ex_wren  = 1'b0;
            w_ex_mem_wren = 1'b0;
            w_stall_inc   = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (ex_branch_taken) begin
                        // Branch beats load-use: the dependent
                        // instruction is discarded anyway.
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                        w_flush_inc    = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_wren      = 1'b0;
                        w_if_id_wren   = 1'b0;
                        w_id_ex_bubble = 1'b1;
                        w_stall_inc    = 1'b1;
                        if (LOAD_USE_STALL_CYCLES > 1) begin
                            w_state_nxt = S_LOAD_STALL;
                            w_cnt_nxt   = LS_INIT;
                        end
                    end else if (halt_req) begin
                        w_pc_wren      = 1'b0;
                        w_if_id_wren   = 1'b0;
                        w_id_ex_bubble = 1'b1;
                        w_state_nxt    = S_DRAIN;
                        w_cnt_nxt      = DR_INIT;
                    end
                end
                S_LOAD_STALL: begin
                    // EX holds a bubble, so no new hazard or branch.
                    w_pc_wren      = 1'b0;
                    w_if_id_wren   = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    w_stall_inc    = 1'b1;
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                S_DRAIN: begin
                    // Older instructions keep retiring while
                    // bubbles fill in behind them.
                    w_pc_wren      = 1'b0;
                    w_if_id_wren   = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    if (r_cnt == 4'd0) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Sequencer state and down-counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_flush_inc && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    // While in reset the pipe is frozen with a bubble in ID/EX.
    assign pc_wren      = reset_n & w_pc_wren;
    assign if_id_wren   = reset_n & w_if_id_wren;
    assign if_id_flush  = reset_n & w_if_id_flush;
    assign id_ex_wren   = reset_n & w_id_ex_wren;
    assign id_ex_bubble = ~reset_n | w_id_ex_bubble;
    assign ex_mem_wren  = reset_n & w_ex_mem_wren;
    assign halted       = reset_n & w_halted;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two parameter sets against
// a bubble-counting reference model, plus directed scenarios.
module tb_hazard_stall_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_reg_wren, ex_is_load, ex_branch_taken;
    logic       mem_busy, halt_req;

    logic a_pc, a_ifw, a_iff, a_idw, a_bub, a_exw, a_hlt;
    logic b_pc, b_ifw, b_iff, b_idw, b_bub, b_exw, b_hlt;
    logic [31:0] a_stall, a_flush;
    logic [3:0]  b_stall, b_flush;

    logic [6:0]  outv [2];
    logic [63:0] act_st [2];
    logic [63:0] act_fl [2];

    int total = 0;
    int bad = 0;
    bit run_checks = 1'b0;

    // model: bubbles/drain cycles still owed, halted flag, counts
    int     lusc [2] = '{1, 3};
    int     drn  [2] = '{3, 2};
    longint smax [2] = '{64'hFFFF_FFFF, 15};
    int     stall_left [2];
    int     drain_left [2];
    bit     hlt [2];
    longint nst [2];
    longint nfl [2];

    always #5 clk = ~clk;

    hazard_stall_controller #(
        .LOAD_USE_STALL_CYCLES(1), .DRAIN_CYCLES(3), .CNT_WIDTH(32)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_address(ex_rd_address), .ex_reg_wren(ex_reg_wren),
        .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .halt_req(halt_req),
        .pc_wren(a_pc), .if_id_wren(a_ifw), .if_id_flush(a_iff),
        .id_ex_wren(a_idw), .id_ex_bubble(a_bub), .ex_mem_wren(a_exw),
        .halted(a_hlt), .stall_cycles(a_stall), .flush_count(a_flush)
    );

    hazard_stall_controller #(
        .LOAD_USE_STALL_CYCLES(3), .DRAIN_CYCLES(2), .CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_address(ex_rd_address), .ex_reg_wren(ex_reg_wren),
        .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .halt_req(halt_req),
        .pc_wren(b_pc), .if_id_wren(b_ifw), .if_id_flush(b_iff),
        .id_ex_wren(b_idw), .id_ex_bubble(b_bub), .ex_mem_wren(b_exw),
        .halted(b_hlt), .stall_cycles(b_stall), .flush_count(b_flush)
    );

    // outputs packed as {pc, ifid_w, ifid_flush, idex_w, bubble, exmem_w, halted}
    assign outv[0]   = {a_pc, a_ifw, a_iff, a_idw, a_bub, a_exw, a_hlt};
    assign outv[1]   = {b_pc, b_ifw, b_iff, b_idw, b_bub, b_exw, b_hlt};
    assign act_st[0] = 64'(a_stall);
    assign act_st[1] = 64'(b_stall);
    assign act_fl[0] = 64'(a_flush);
    assign act_fl[1] = 64'(b_flush);

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit lu_now();
        return ex_is_load && ex_reg_wren && (ex_rd_address != 5'd0) &&
               ((id_uses_rs1 && id_rs1_address == ex_rd_address) ||
                (id_uses_rs2 && id_rs2_address == ex_rd_address));
    endfunction

    function automatic logic [6:0] model_out(int k);
        if (!reset_n) return 7'b0000100;
        if (hlt[k]) return 7'b0000001;
        if (mem_busy) return 7'b0000000;
        if (stall_left[k] > 0 || drain_left[k] > 0) return 7'b0001110;
        if (ex_branch_taken) return 7'b1111110;
        if (lu_now() || halt_req) return 7'b0001110;
        return 7'b1101010;
    endfunction

    function automatic logic [63:0] sat(longint v, longint m);
        return (v > m) ? 64'(m) : 64'(v);
    endfunction

    // reference model advance
    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                stall_left[k] = 0; drain_left[k] = 0; hlt[k] = 1'b0;
                nst[k] = 0; nfl[k] = 0;
            end else if (hlt[k]) begin
                if (!halt_req) hlt[k] = 1'b0;
            end else if (mem_busy) begin
                nst[k]++;
            end else if (stall_left[k] > 0) begin
                nst[k]++; stall_left[k]--;
            end else if (drain_left[k] > 0) begin
                drain_left[k]--;
                if (drain_left[k] == 0) hlt[k] = 1'b1;
            end else if (ex_branch_taken) begin
                nfl[k]++;
            end else if (lu_now()) begin
                nst[k]++; stall_left[k] = lusc[k] - 1;
            end else if (halt_req) begin
                drain_left[k] = drn[k];
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (run_checks) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d outs", k), 64'(outv[k]), 64'(model_out(k)));
                chk($sformatf("dut%0d stall_cycles", k), act_st[k], sat(nst[k], smax[k]));
                chk($sformatf("dut%0d flush_count", k), act_fl[k], sat(nfl[k], smax[k]));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1_address = 5'd0; id_rs2_address = 5'd0; ex_rd_address = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_reg_wren = 1'b0;
        ex_is_load = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        halt_req = 1'b0;
    endtask

    task automatic set_lw5();
        ex_is_load = 1'b1; ex_reg_wren = 1'b1; ex_rd_address = 5'd5;
        id_uses_rs2 = 1'b1; id_rs2_address = 5'd5;
    endtask

    task automatic do_reset();
        nxt(); clr(); reset_n = 1'b0;
        nxt(); reset_n = 1'b1;
    endtask

    initial begin
        clr();
        repeat (2) @(posedge clk);
        run_checks = 1'b1;

        @(negedge clk);
        chk("reset outs", 64'(outv[0]), 64'(7'b0000100));
        chk("reset stall", act_st[0], 64'd0);
        chk("reset flush", act_fl[0], 64'd0);
        nxt(); reset_n = 1'b1;

        // single-cycle load-use on A
        set_lw5();
        @(negedge clk);
        chk("lu stall outs", 64'(outv[0]), 64'(7'b0001110));
        nxt(); clr();
        @(negedge clk);
        chk("lu resume outs", 64'(outv[0]), 64'(7'b1101010));
        chk("lu stall count", act_st[0], 64'd1);

        // branch wins over load-use
        do_reset();
        set_lw5(); ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("br outs A", 64'(outv[0]), 64'(7'b1111110));
        chk("br outs B", 64'(outv[1]), 64'(7'b1111110));
        nxt(); clr();
        @(negedge clk);
        chk("br flush count", act_fl[0], 64'd1);
        chk("br stall count", act_st[0], 64'd0);

        // B: three bubbles with two frozen cycles in between
        do_reset();
        set_lw5();
        @(negedge clk); chk("ls3 c1", 64'(outv[1]), 64'(7'b0001110));
        nxt(); mem_busy = 1'b1;
        @(negedge clk); chk("ls3 c2", 64'(outv[1]), 64'(7'b0000000));
        nxt();
        @(negedge clk); chk("ls3 c3", 64'(outv[1]), 64'(7'b0000000));
        nxt(); mem_busy = 1'b0;
        @(negedge clk); chk("ls3 c4", 64'(outv[1]), 64'(7'b0001110));
        nxt();
        @(negedge clk); chk("ls3 c5", 64'(outv[1]), 64'(7'b0001110));
        nxt(); clr();
        @(negedge clk);
        chk("ls3 resume", 64'(outv[1]), 64'(7'b1101010));
        chk("ls3 stall count", act_st[1], 64'd5);

        // A: halt accept + 3 drain bubbles, halted on 5th cycle
        do_reset();
        halt_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("halt drain c%0d", i), 64'(outv[0]), 64'(7'b0001110));
            nxt();
        end
        @(negedge clk); chk("halt c5", 64'(outv[0]), 64'(7'b0000001));
        nxt(); halt_req = 1'b0; mem_busy = 1'b1;
        @(negedge clk); chk("halt exit cyc", 64'(outv[0]), 64'(7'b0000001));
        nxt(); mem_busy = 1'b0;
        @(negedge clk); chk("halt resumed", 64'(outv[0]), 64'(7'b1101010));

        // B: async reset while in LOAD_STALL
        do_reset();
        set_lw5();
        nxt();
        @(negedge clk); chk("mid stall outs", 64'(outv[1]), 64'(7'b0001110));
        #2 reset_n = 1'b0;
        #1;
        chk("async rst outs", 64'(outv[1]), 64'(7'b0000100));
        chk("async rst stall", act_st[1], 64'd0);
        nxt(); clr(); reset_n = 1'b1;
        @(negedge clk); chk("post rst outs", 64'(outv[1]), 64'(7'b1101010));

        // rd = x0 never stalls
        nxt();
        ex_is_load = 1'b1; ex_reg_wren = 1'b1; ex_rd_address = 5'd0;
        id_uses_rs1 = 1'b1; id_rs1_address = 5'd0;
        @(negedge clk);
        chk("x0 outs A", 64'(outv[0]), 64'(7'b1101010));
        chk("x0 outs B", 64'(outv[1]), 64'(7'b1101010));

        // randomized traffic
        nxt(); clr();
        repeat (4000) begin
            nxt();
            if (!reset_n) reset_n = 1'b1;
            ex_rd_address   = 5'($urandom_range(0, 3));
            id_rs1_address  = 5'($urandom_range(0, 3));
            id_rs2_address  = 5'($urandom_range(0, 3));
            id_uses_rs1     = ($urandom_range(0, 1) == 0);
            id_uses_rs2     = ($urandom_range(0, 1) == 0);
            ex_is_load      = ($urandom_range(0, 2) == 0);
            ex_reg_wren     = ($urandom_range(0, 3) != 0);
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            mem_busy        = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
            end
        end

        nxt();
        reset_n = 1'b1;
        @(negedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
